// File: rtl/glb_stream_sink_if.sv
// Valid/ready stream port carrying GLB sparse-stream words into a sink.
interface glb_stream_sink_if #(
  parameter int DATA_WIDTH = 17
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glb_stream_sink.sv
// GLB stream sink: captures framed sparse-stream transactions into a readable
// buffer, with LFSR ready throttling, overflow and trailing-valid detection.
module glb_stream_sink #(
  parameter int          DATA_WIDTH     = 17,
  parameter int          DEPTH          = 4096,
  parameter int          THROTTLE_SHIFT = 0,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  localparam int         AW             = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  glb_stream_sink_if.slave      s_in,
  input  logic                  i_flush,
  input  logic [15:0]           i_cfg_tx_num,
  input  logic                  i_cfg_seg_mode,
  input  logic                  i_cfg_throttle_en,
  output logic                  o_done,
  output logic [AW:0]           o_num_rx,
  output logic                  o_overflow_err,
  output logic                  o_trailing_valid_err,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);
  localparam logic [AW:0] NUM_FULL = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_ARM, S_HEADER, S_LEN, S_DATA, S_DONE
  } state_t;

  state_t                r_state;
  logic                  r_ready;
  logic                  r_done;
  logic [AW:0]           r_num_rx;
  logic                  r_ovf;
  logic                  r_trail;
  logic [15:0]           r_tx_num;
  logic                  r_seg_mode;
  logic [1:0]            r_arm_cnt;
  logic [15:0]           r_tx_cnt;
  logic [1:0]            r_seg_rem;
  logic [DATA_WIDTH-1:0] r_len_cnt;
  logic [1:0]            r_stall;
  logic [15:0]           r_lfsr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic       w_accept;
  logic       w_wr_en;
  logic [1:0] w_stall_ld;
  logic [1:0] w_stall_nxt;
  logic       w_rdy_nxt;
  logic       w_last_tx;

  assign w_accept   = s_in.valid && r_ready;
  assign w_wr_en    = w_accept && !i_flush && (r_num_rx != NUM_FULL);
  assign w_stall_ld = i_cfg_throttle_en ? r_lfsr[THROTTLE_SHIFT +: 2] : 2'd0;
  assign w_rdy_nxt  = (w_stall_nxt == 2'd0);
  assign w_last_tx  = ((r_tx_cnt + 16'd1) == r_tx_num);

  always_comb begin
    w_stall_nxt = 2'd0;
    if (w_accept)
      w_stall_nxt = w_stall_ld;
    else if (r_stall != 2'd0)
      w_stall_nxt = r_stall - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_lfsr <= LFSR_SEED;
    else
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end

  // Flush overrides everything, including a beat presented in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_num_rx   <= '0;
      r_ovf      <= 1'b0;
      r_trail    <= 1'b0;
      r_tx_num   <= '0;
      r_seg_mode <= 1'b0;
      r_arm_cnt  <= '0;
      r_tx_cnt   <= '0;
      r_seg_rem  <= '0;
      r_len_cnt  <= '0;
      r_stall    <= '0;
    end else if (i_flush) begin
      r_state  <= S_FLUSH;
      r_ready  <= 1'b0;
      r_done   <= 1'b0;
      r_num_rx <= '0;
      r_ovf    <= 1'b0;
      r_trail  <= 1'b0;
      r_tx_cnt <= '0;
      r_seg_rem <= '0;
      r_stall  <= '0;
    end else begin
      r_stall <= w_stall_nxt;
      r_ready <= w_rdy_nxt;
      if (w_accept) begin
        if (r_num_rx == NUM_FULL) r_ovf <= 1'b1;
        else                      r_num_rx <= r_num_rx + 1'b1;
      end
      case (r_state)
        S_IDLE: r_ready <= 1'b0;
        S_FLUSH: begin
          r_ready    <= 1'b0;
          r_tx_num   <= i_cfg_tx_num;
          r_seg_mode <= i_cfg_seg_mode;
          r_arm_cnt  <= 2'd3;
          r_state    <= S_ARM;
        end
        S_ARM: begin
          r_ready <= 1'b0;
          if (r_arm_cnt == 2'd1) begin
            if (r_tx_num == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_HEADER;
              r_ready <= w_rdy_nxt;
            end
          end else begin
            r_arm_cnt <= r_arm_cnt - 2'd1;
          end
        end
        S_HEADER: if (w_accept) begin
          r_seg_rem <= r_seg_mode ? 2'd2 : 2'd1;
          r_state   <= S_LEN;
        end
        S_LEN: if (w_accept) begin
          r_seg_rem <= r_seg_rem - 2'd1;
          if (s_in.data != '0) begin
            r_len_cnt <= s_in.data;
            r_state   <= S_DATA;
          end else if (r_seg_rem == 2'd1) begin
            r_tx_cnt <= r_tx_cnt + 16'd1;
            if (w_last_tx) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_HEADER;
            end
          end
        end
        S_DATA: if (w_accept) begin
          r_len_cnt <= r_len_cnt - 1'b1;
          if (r_len_cnt == DATA_WIDTH'(1)) begin
            if (r_seg_rem != 2'd0) begin
              r_state <= S_LEN;
            end else begin
              r_tx_cnt <= r_tx_cnt + 16'd1;
              if (w_last_tx) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_ready <= 1'b0;
              end else begin
                r_state <= S_HEADER;
              end
            end
          end
        end
        S_DONE: begin
          r_ready <= 1'b0;
          if (s_in.valid) r_trail <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  // Buffer is intentionally not reset; reads return old data on collision.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_num_rx[AW-1:0]] <= s_in.data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[i_rd_addr];
  end

  assign s_in.ready           = r_ready;
  assign o_done               = r_done;
  assign o_num_rx             = r_num_rx;
  assign o_overflow_err       = r_ovf;
  assign o_trailing_valid_err = r_trail;
  assign o_rd_data            = r_rd_data;
endmodule

// File: tb/tb_glb_stream_sink.sv
// Self-checking bench for glb_stream_sink: directed framing cases plus random
// transactions, checked against a stream-parsing reference model.
module tb_glb_stream_sink;
  localparam int          DW    = 17;
  localparam int          DEPTH = 32;
  localparam int          AW    = $clog2(DEPTH);
  localparam int          SHIFT = 0;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          flush = 1'b0;
  logic [15:0]   cfg_tx_num = '0;
  logic          cfg_seg_mode = 1'b0;
  logic          cfg_throttle_en = 1'b0;
  logic          done, ovf, trail;
  logic [AW:0]   num_rx;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;

  glb_stream_sink_if #(.DATA_WIDTH(DW)) bus();

  glb_stream_sink #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .THROTTLE_SHIFT(SHIFT), .LFSR_SEED(SEED)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .s_in(bus.slave),
    .i_flush(flush), .i_cfg_tx_num(cfg_tx_num), .i_cfg_seg_mode(cfg_seg_mode),
    .i_cfg_throttle_en(cfg_throttle_en),
    .o_done(done), .o_num_rx(num_rx), .o_overflow_err(ovf),
    .o_trailing_valid_err(trail), .i_rd_addr(rd_addr), .o_rd_data(rd_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference throttle LFSR: 16-bit Fibonacci, taps 16,14,13,11.
  logic [15:0] m_lfsr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
  end

  logic [DW-1:0] w [128];
  int            nw;
  logic [DW-1:0] exp_mem [DEPTH];
  int            m_cnt;

  function automatic void push(input logic [DW-1:0] v);
    w[nw] = v;
    nw++;
  endfunction

  // Beats until done: header, then per segment a length word plus that many words.
  function automatic int frame_beats(input int tx, input bit seg2);
    int pos = 0;
    for (int t = 0; t < tx; t++) begin
      pos++;
      for (int s = 0; s < (seg2 ? 2 : 1); s++) pos += 1 + int'(w[pos]);
    end
    return pos;
  endfunction

  task automatic do_flush(input int tx, input bit seg, input bit thr);
    int c;
    @(negedge clk);
    flush = 1'b1; cfg_tx_num = 16'(tx); cfg_seg_mode = seg; cfg_throttle_en = thr;
    @(negedge clk);
    chk("flush_num_rx", 32'(num_rx), 0);
    chk("flush_ready", 32'(bus.ready), 0);
    chk("flush_errs", {30'd0, ovf, trail}, 0);
    chk("flush_done", 32'(done), 0);
    flush = 1'b0;
    m_cnt = 0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!(bus.ready || done) && c < 12);
    chk("arm_latency", 32'(c), 4);
    chk("armed_ready", 32'(bus.ready), 32'(tx != 0));
    chk("armed_done", 32'(done), 32'(tx == 0));
  endtask

  task automatic send(input int n, input bit exp_done);
    int idx = 0, cyc = 0, last = 0, stall = 0;
    bit acc;
    while (idx < n && cyc < 8 * n + 40) begin
      @(negedge clk);
      bus.data = w[idx];
      bus.valid = 1'b1;
      acc = bus.ready;
      if (acc) begin
        if (idx > 0) chk("ready_gap", 32'(cyc - last), 32'(1 + stall));
        last = cyc;
        stall = cfg_throttle_en ? int'((m_lfsr >> SHIFT) & 16'd3) : 0;
        if (m_cnt < DEPTH) exp_mem[m_cnt] = w[idx];
        m_cnt++;
        if (idx == n - 1) chk("done_early", 32'(done), 0);
      end
      @(posedge clk);
      if (acc) idx++;
      cyc++;
    end
    if (idx < n) chk("send_timeout", 32'(idx), 32'(n));
    @(negedge clk);
    bus.valid = 1'b0;
    chk("done", 32'(done), 32'(exp_done));
    chk("num_rx", 32'(num_rx), 32'((m_cnt > DEPTH) ? DEPTH : m_cnt));
    chk("overflow", 32'(ovf), 32'(m_cnt > DEPTH));
  endtask

  task automatic readback(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      rd_addr = AW'(i);
      @(negedge clk);
      chk("rd_data", 32'(rd_data), 32'(exp_mem[i]));
    end
  endtask

  initial begin
    int tx, n;
    bit seg;
    bus.data = '0;
    bus.valid = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #5;
    chk("rst_ready", 32'(bus.ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_num_rx", 32'(num_rx), 0);
    chk("rst_errs", {30'd0, ovf, trail}, 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic single-segment transaction
    nw = 0;
    push(17'h5); push(17'h3); push(17'hA); push(17'hB); push(17'hC);
    do_flush(1, 1'b0, 1'b0);
    send(frame_beats(1, 1'b0), 1'b1);
    readback(5);

    // Two segmented transactions
    nw = 0;
    for (int t = 0; t < 2; t++) begin
      push(DW'($urandom)); push(17'd2); push(DW'($urandom)); push(DW'($urandom));
      push(17'd1); push(DW'($urandom));
    end
    do_flush(2, 1'b1, 1'b0);
    n = frame_beats(2, 1'b1);
    chk("seg_beats", 32'(n), 12);
    send(n, 1'b1);
    chk("seg_trail", 32'(trail), 0);
    readback(n);

    // Zero-length segments
    nw = 0;
    push(17'h1AB); push(17'd0); push(17'd0);
    push(17'h0CD); push(17'd0); push(17'd1); push(17'h155);
    do_flush(2, 1'b1, 1'b0);
    n = frame_beats(2, 1'b1);
    chk("zero_beats", 32'(n), 7);
    send(n, 1'b1);
    readback(n);

    // Random framing
    for (int it = 0; it < 4; it++) begin
      tx = $urandom_range(1, 3);
      seg = 1'($urandom_range(0, 1));
      nw = 0;
      for (int t = 0; t < tx; t++) begin
        push(DW'($urandom));
        for (int s = 0; s < (seg ? 2 : 1); s++) begin
          int len;
          len = $urandom_range(0, 3);
          push(DW'(len));
          for (int k = 0; k < len; k++) push(DW'($urandom));
        end
      end
      do_flush(tx, seg, 1'b0);
      n = frame_beats(tx, seg);
      send(n, 1'b1);
      readback(n);
    end

    // Throttled 20-word transaction
    nw = 0;
    push(DW'($urandom)); push(17'd18);
    for (int k = 0; k < 18; k++) push(DW'($urandom));
    do_flush(1, 1'b0, 1'b1);
    send(frame_beats(1, 1'b0), 1'b1);
    readback(20);
    cfg_throttle_en = 1'b0;

    // Overflow then trailing valid
    nw = 0;
    push(DW'($urandom)); push(17'd32);
    for (int k = 0; k < 32; k++) push(DW'($urandom));
    do_flush(1, 1'b0, 1'b0);
    send(frame_beats(1, 1'b0), 1'b1);
    readback(DEPTH);
    @(negedge clk); bus.valid = 1'b1;
    @(negedge clk); bus.valid = 1'b0;
    chk("trailing_err", 32'(trail), 1);
    chk("trailing_done", 32'(done), 1);

    // Flush mid-DATA, then a clean restart
    nw = 0;
    push(17'h11); push(17'd5);
    for (int k = 0; k < 5; k++) push(DW'($urandom));
    do_flush(1, 1'b0, 1'b0);
    send(4, 1'b0);
    nw = 0;
    push(17'h22); push(17'd1); push(17'h1F0F0);
    do_flush(1, 1'b0, 1'b0);
    send(frame_beats(1, 1'b0), 1'b1);
    readback(3);

    // tx_num == 0
    do_flush(0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tx0_ready", 32'(bus.ready), 0);

    // Asynchronous reset mid-stream
    nw = 0;
    push(17'h33); push(17'd4);
    for (int k = 0; k < 4; k++) push(DW'($urandom));
    do_flush(1, 1'b0, 1'b0);
    send(3, 1'b0);
    @(negedge clk);
    bus.valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(bus.ready), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_num_rx", 32'(num_rx), 0);
    chk("mid_rst_errs", {30'd0, ovf, trail}, 0);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    bus.valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
